// File: rtl/bus_arbiter.sv
// Two-manager round-robin arbiter in front of one shared subordinate.
// Each manager owns a one-deep pending buffer; WAIT aborts on timeout.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_rw_address,
  input  logic        m0_read_request,
  input  logic        m0_write_request,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_write_strobe,
  output logic [31:0] m0_read_data,
  output logic        m0_read_response,
  output logic        m0_write_response,
  input  logic [31:0] m1_rw_address,
  input  logic        m1_read_request,
  input  logic        m1_write_request,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_write_strobe,
  output logic [31:0] m1_read_data,
  output logic        m1_read_response,
  output logic        m1_write_response,
  output logic [31:0] s_rw_address,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_write_strobe,
  output logic        s_read_request,
  output logic        s_write_request,
  input  logic [31:0] s_read_data,
  input  logic        s_read_response,
  input  logic        s_write_response,
  output logic        busy,
  output logic        timeout_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [7:0]  count;
  logic        owner;
  logic        last_grant;
  logic        s_is_read;

  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [31:0] req_addr [2];
  logic [31:0] req_data [2];
  logic [3:0]  req_strb [2];

  logic [1:0]  buf_valid;
  logic [1:0]  buf_read;
  logic [31:0] buf_addr [2];
  logic [31:0] buf_data [2];
  logic [3:0]  buf_strb [2];

  logic [1:0]  grant;
  logic        sel;
  logic        hit;
  logic        expire;

  logic [1:0]  rd_rsp;
  logic [1:0]  wr_rsp;
  logic [31:0] rd_data [2];

  assign req_rd      = {m1_read_request, m0_read_request};
  assign req_wr      = {m1_write_request, m0_write_request};
  assign req_addr[0] = m0_rw_address;
  assign req_addr[1] = m1_rw_address;
  assign req_data[0] = m0_write_data;
  assign req_data[1] = m1_write_data;
  assign req_strb[0] = m0_write_strobe;
  assign req_strb[1] = m1_write_strobe;

  // Tie goes to the manager that did not complete last.
  assign grant[0] = (state == IDLE) && buf_valid[0]
                  && (!buf_valid[1] || last_grant);
  assign grant[1] = (state == IDLE) && buf_valid[1]
                  && (!buf_valid[0] || !last_grant);
  assign sel = grant[1];

  assign hit = s_is_read ? s_read_response
                         : s_write_response;
  assign expire = !hit
               && (({1'b0, count} + 9'd1) == TMO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_valid[i] <= 1'b0;
        buf_read[i]  <= 1'b0;
        buf_addr[i]  <= 32'h0;
        buf_data[i]  <= 32'h0;
        buf_strb[i]  <= 4'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end else if (!buf_valid[i]
                     && (req_rd[i] || req_wr[i])) begin
          buf_valid[i] <= 1'b1;
          buf_read[i]  <= req_rd[i];
          buf_addr[i]  <= req_addr[i];
          buf_data[i]  <= req_data[i];
          buf_strb[i]  <= req_strb[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= 8'd0;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      s_is_read     <= 1'b0;
      s_rw_address  <= 32'h0;
      s_write_data  <= 32'h0;
      s_write_strobe <= 4'h0;
      rd_rsp        <= 2'b00;
      wr_rsp        <= 2'b00;
      rd_data[0]    <= 32'h0;
      rd_data[1]    <= 32'h0;
      timeout_error <= 1'b0;
    end else begin
      rd_rsp        <= 2'b00;
      wr_rsp        <= 2'b00;
      timeout_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|grant) begin
            owner          <= sel;
            s_is_read      <= buf_read[sel];
            s_rw_address   <= buf_addr[sel];
            s_write_data   <= buf_data[sel];
            s_write_strobe <= buf_strb[sel];
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          count <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          if (hit || expire) begin
            if (s_is_read) begin
              rd_rsp[owner]  <= 1'b1;
              rd_data[owner] <= hit ? s_read_data
                                    : 32'h0;
            end else begin
              wr_rsp[owner] <= 1'b1;
            end
            timeout_error <= expire;
            last_grant    <= owner;
            state         <= IDLE;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_read_request  = (state == ISSUE) && s_is_read;
  assign s_write_request = (state == ISSUE) && !s_is_read;
  assign busy            = (state != IDLE);

  assign m0_read_response  = rd_rsp[0];
  assign m1_read_response  = rd_rsp[1];
  assign m0_write_response = wr_rsp[0];
  assign m1_write_response = wr_rsp[1];
  assign m0_read_data      = rd_data[0];
  assign m1_read_data      = rd_data[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed manager traffic,
// a simple subordinate model and a response monitor.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_rw_address = 32'h0;
  logic        m0_read_request = 1'b0;
  logic        m0_write_request = 1'b0;
  logic [31:0] m0_write_data = 32'h0;
  logic [3:0]  m0_write_strobe = 4'h0;
  logic [31:0] m0_read_data;
  logic        m0_read_response;
  logic        m0_write_response;
  logic [31:0] m1_rw_address = 32'h0;
  logic        m1_read_request = 1'b0;
  logic        m1_write_request = 1'b0;
  logic [31:0] m1_write_data = 32'h0;
  logic [3:0]  m1_write_strobe = 4'h0;
  logic [31:0] m1_read_data;
  logic        m1_read_response;
  logic        m1_write_response;
  logic [31:0] s_rw_address;
  logic [31:0] s_write_data;
  logic [3:0]  s_write_strobe;
  logic        s_read_request;
  logic        s_write_request;
  logic [31:0] s_read_data = 32'h0;
  logic        s_read_response = 1'b0;
  logic        s_write_response = 1'b0;
  logic        busy;
  logic        timeout_error;

  typedef struct packed {
    logic        mgr;
    logic        rd;
    logic        tmo;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [3:0]  mon_r;
  logic [3:0]  mon_x;
  int          checks = 0;
  int          errors = 0;

  logic        sub_en = 1'b1;
  logic        stray = 1'b0;
  logic [31:0] sub_rdata = 32'h0;
  logic        sub_rr;
  logic        sub_wr;

  always #5 clock = ~clock;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .m0_rw_address    (m0_rw_address),
    .m0_read_request  (m0_read_request),
    .m0_write_request (m0_write_request),
    .m0_write_data    (m0_write_data),
    .m0_write_strobe  (m0_write_strobe),
    .m0_read_data     (m0_read_data),
    .m0_read_response (m0_read_response),
    .m0_write_response(m0_write_response),
    .m1_rw_address    (m1_rw_address),
    .m1_read_request  (m1_read_request),
    .m1_write_request (m1_write_request),
    .m1_write_data    (m1_write_data),
    .m1_write_strobe  (m1_write_strobe),
    .m1_read_data     (m1_read_data),
    .m1_read_response (m1_read_response),
    .m1_write_response(m1_write_response),
    .s_rw_address     (s_rw_address),
    .s_write_data     (s_write_data),
    .s_write_strobe   (s_write_strobe),
    .s_read_request   (s_read_request),
    .s_write_request  (s_write_request),
    .s_read_data      (s_read_data),
    .s_read_response  (s_read_response),
    .s_write_response (s_write_response),
    .busy             (busy),
    .timeout_error    (timeout_error)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h",
               name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic mgr, input logic rd,
                      input logic [31:0] data,
                      input logic tmo);
    exp_t e;
    e.mgr  = mgr;
    e.rd   = rd;
    e.tmo  = tmo;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive(input logic mgr, input logic rd,
                       input logic wr,
                       input logic [31:0] addr,
                       input logic [31:0] data,
                       input logic [3:0] strb);
    if (!mgr) begin
      m0_read_request  = rd;
      m0_write_request = wr;
      m0_rw_address    = addr;
      m0_write_data    = data;
      m0_write_strobe  = strb;
    end else begin
      m1_read_request  = rd;
      m1_write_request = wr;
      m1_rw_address    = addr;
      m1_write_data    = data;
      m1_write_strobe  = strb;
    end
  endtask

  task automatic clr();
    m0_read_request  = 1'b0;
    m0_write_request = 1'b0;
    m1_read_request  = 1'b0;
    m1_write_request = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk(name, sb.size(), 0);
    chk({name, "_busy"}, {31'b0, busy}, 0);
  endtask

  // Subordinate: answers one cycle after a request pulse.
  initial begin
    forever begin
      @(negedge clock);
      sub_rr = (s_read_request && sub_en) || stray;
      sub_wr = s_write_request && sub_en;
      @(posedge clock);
      #1;
      s_read_response  = sub_rr;
      s_write_response = sub_wr;
      s_read_data      = sub_rdata;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      mon_r = {m1_write_response, m1_read_response,
               m0_write_response, m0_read_response};
      if (reset && mon_r != 4'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %b required 0000",
                   mon_r);
        end else begin
          mon_e = sb.pop_front();
          mon_x = mon_e.mgr
                ? (mon_e.rd ? 4'b0100 : 4'b1000)
                : (mon_e.rd ? 4'b0001 : 4'b0010);
          chk("rsp_kind", {28'b0, mon_r}, {28'b0, mon_x});
          chk("rsp_tmo", {31'b0, timeout_error},
              {31'b0, mon_e.tmo});
          if (mon_e.rd)
            chk("rsp_data",
                mon_e.mgr ? m1_read_data : m0_read_data,
                mon_e.data);
        end
      end else if (reset && timeout_error) begin
        checks++;
        errors++;
        $display("FAIL stray_tmo: got 1 required 0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_srd", {31'b0, s_read_request}, 0);
    chk("rst_swr", {31'b0, s_write_request}, 0);
    chk("rst_addr", s_rw_address, 0);
    chk("rst_strb", {28'b0, s_write_strobe}, 0);
    chk("rst_tmo", {31'b0, timeout_error}, 0);
    chk("rst_m0rd", m0_read_data, 0);
    reset = 1'b1;
    tick();

    // Tie after reset: m0 first, then m1.
    sub_rdata = 32'h0BAD_0001;
    drive(0, 0, 1, 32'h10, 32'hCAFE_F00D, 4'hF);
    drive(1, 1, 0, 32'h20, 32'h0, 4'h0);
    push(0, 0, 32'h0, 0);
    push(1, 1, 32'h0BAD_0001, 0);
    tick();
    clr();
    tick();
    chk("a_swr", {31'b0, s_write_request}, 1);
    chk("a_addr", s_rw_address, 32'h10);
    chk("a_data", s_write_data, 32'hCAFE_F00D);
    chk("a_strb", {28'b0, s_write_strobe}, 32'hF);
    chk("a_busy", {31'b0, busy}, 1);
    drain("a_drain");

    // Uncontested read latency.
    sub_rdata = 32'h1234_5678;
    drive(0, 1, 0, 32'h4, 32'h0, 4'h0);
    push(0, 1, 32'h1234_5678, 0);
    tick();
    clr();
    chk("b_srd_t1", {31'b0, s_read_request}, 0);
    tick();
    chk("b_srd_t2", {31'b0, s_read_request}, 1);
    chk("b_addr", s_rw_address, 32'h4);
    tick();
    chk("b_rsp_t3", {31'b0, m0_read_response}, 0);
    tick();
    chk("b_rsp_t4", {31'b0, m0_read_response}, 1);
    chk("b_data", m0_read_data, 32'h1234_5678);
    drain("b_drain");

    // m0 completed last, so the next tie goes to m1.
    drive(0, 0, 1, 32'h30, 32'h1111_2222, 4'h3);
    drive(1, 0, 1, 32'h40, 32'h3333_4444, 4'hC);
    push(1, 0, 32'h0, 0);
    push(0, 0, 32'h0, 0);
    tick();
    clr();
    tick();
    chk("c_addr", s_rw_address, 32'h40);
    chk("c_data", s_write_data, 32'h3333_4444);
    chk("c_strb", {28'b0, s_write_strobe}, 32'hC);
    drain("c_drain");
    chk("c_hold_rd", m0_read_data, 32'h1234_5678);
    chk("c_hold_addr", s_rw_address, 32'h30);

    // Second m1 request while its buffer is full is dropped.
    sub_rdata = 32'hA5A5_5A5A;
    drive(1, 1, 0, 32'h50, 32'h0, 4'h0);
    push(1, 1, 32'hA5A5_5A5A, 0);
    tick();
    drive(1, 0, 1, 32'h60, 32'h7777_7777, 4'hF);
    tick();
    clr();
    chk("d_srd", {31'b0, s_read_request}, 1);
    drain("d_drain");
    repeat (6) tick();
    chk("d_addr", s_rw_address, 32'h50);

    // Silent subordinate: m0 read times out, then m1 write.
    sub_en = 1'b0;
    drive(0, 1, 0, 32'h70, 32'h0, 4'h0);
    drive(1, 0, 1, 32'h80, 32'hFEED_BEEF, 4'hF);
    push(0, 1, 32'h0, 1);
    push(1, 0, 32'h0, 0);
    tick();
    clr();
    tick();
    chk("e_srd", {31'b0, s_read_request}, 1);
    repeat (4) tick();
    chk("e_tmo_early", {31'b0, timeout_error}, 0);
    chk("e_rsp_early", {31'b0, m0_read_response}, 0);
    sub_en = 1'b1;
    tick();
    chk("e_tmo", {31'b0, timeout_error}, 1);
    chk("e_rsp", {31'b0, m0_read_response}, 1);
    chk("e_zero", m0_read_data, 32'h0);
    drain("e_drain");
    chk("e_addr", s_rw_address, 32'h80);

    // Reset in WAIT, then a stray read response.
    sub_en = 1'b0;
    drive(0, 1, 0, 32'h90, 32'h0, 4'h0);
    tick();
    clr();
    repeat (3) tick();
    chk("f_busy_wait", {31'b0, busy}, 1);
    reset = 1'b0;
    tick();
    chk("f_busy_rst", {31'b0, busy}, 0);
    chk("f_addr_rst", s_rw_address, 32'h0);
    reset = 1'b1;
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    tick();
    chk("f_busy", {31'b0, busy}, 0);
    chk("f_m0rsp", {31'b0, m0_read_response}, 0);
    sub_en = 1'b1;
    sub_rdata = 32'h5555_AAAA;
    drive(1, 1, 0, 32'hA0, 32'h0, 4'h0);
    push(1, 1, 32'h5555_AAAA, 0);
    tick();
    clr();
    drain("f_drain");
    chk("f_m1data", m1_read_data, 32'h5555_AAAA);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
